bht_update_queue: RTL and testbench

- Write-side companion to the tournament branch predictor.
- Records every prediction issued on the predictor read port (index plus predicted direction) in an in-order queue.
- When the back end resolves the oldest branch, it pops the entry and drives the predictor write port (w_v/w_idx/correct). It also supplies the recovered actual direction for GHR/LHT training.
- Sits between the fetch-side predictor read and the execute-side branch resolution.

---
 rtl/bht_update_queue.sv | 149 ++++++++++++++
 tb/tb_bht_update_queue.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/bht_update_queue.sv
// In-order queue of issued branch predictions. Resolutions pop the oldest entry
// and drive registered predictor-update outputs plus a saturating mispredict count.
module bht_update_queue #(
  parameter int bht_idx_width_p = 10,
  parameter int depth_p         = 4,
  parameter int stat_width_p    = 16
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               pred_v_i,
  input  logic [bht_idx_width_p-1:0]         pred_idx_i,
  input  logic                               pred_taken_i,
  output logic                               pred_ready_o,
  input  logic                               res_v_i,
  input  logic                               res_taken_i,
  input  logic                               flush_i,
  output logic                               w_v_o,
  output logic [bht_idx_width_p-1:0]         w_idx_o,
  output logic                               correct_o,
  output logic                               actual_taken_o,
  output logic                               mispredict_o,
  output logic [$clog2(depth_p+1)-1:0]       count_o,
  output logic [stat_width_p-1:0]            mispredict_cnt_o,
  output logic                               err_o
);

  localparam int cnt_w_lp = $clog2(depth_p + 1);
  localparam int ptr_w_lp = $clog2(depth_p);
  localparam logic [cnt_w_lp-1:0]     depth_lp    = cnt_w_lp'(depth_p);
  localparam logic [stat_width_p-1:0] stat_max_lp = {stat_width_p{1'b1}};

  logic [bht_idx_width_p-1:0] mem_idx_q   [depth_p];
  logic                       mem_taken_q [depth_p];

  logic [ptr_w_lp-1:0]        head_q, head_d;
  logic [ptr_w_lp-1:0]        tail_q, tail_d;
  logic [cnt_w_lp-1:0]        count_q, count_d;
  logic                       w_v_q, w_v_d;
  logic [bht_idx_width_p-1:0] w_idx_q, w_idx_d;
  logic                       correct_q, correct_d;
  logic                       actual_q, actual_d;
  logic                       mispredict_q, mispredict_d;
  logic [stat_width_p-1:0]    stat_q, stat_d;
  logic                       err_q, err_d;

  logic push_s;
  logic pop_s;
  logic not_full_s;
  logic head_match_s;

  // Ready is derived from the registered count only; held low while in reset.
  assign not_full_s   = (count_q < depth_lp);
  assign pred_ready_o = !reset_i && not_full_s;

  assign push_s       = pred_v_i && not_full_s && !flush_i;
  assign pop_s        = res_v_i && (count_q != {cnt_w_lp{1'b0}});
  assign head_match_s = (mem_taken_q[head_q] == res_taken_i);

  // Next-state for pointers, occupancy, update outputs and statistics.
  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    w_v_d        = 1'b0;
    w_idx_d      = w_idx_q;
    correct_d    = correct_q;
    actual_d     = actual_q;
    mispredict_d = 1'b0;
    stat_d       = stat_q;
    err_d        = err_q;

    if (pop_s) begin
      w_v_d        = 1'b1;
      w_idx_d      = mem_idx_q[head_q];
      correct_d    = head_match_s;
      actual_d     = res_taken_i;
      mispredict_d = !head_match_s;
      if (!head_match_s && (stat_q != stat_max_lp)) begin
        stat_d = stat_q + {{(stat_width_p-1){1'b0}}, 1'b1};
      end else begin
        stat_d = stat_q;
      end
    end else begin
      w_v_d = 1'b0;
    end

    // A resolution with nothing outstanding is a protocol error; same-cycle push cannot satisfy it.
    if (res_v_i && (count_q == {cnt_w_lp{1'b0}})) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end

    if (flush_i) begin
      head_d  = {ptr_w_lp{1'b0}};
      tail_d  = {ptr_w_lp{1'b0}};
      count_d = {cnt_w_lp{1'b0}};
    end else begin
      head_d  = head_q + ptr_w_lp'(pop_s);
      tail_d  = tail_q + ptr_w_lp'(push_s);
      count_d = count_q + cnt_w_lp'(push_s) - cnt_w_lp'(pop_s);
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      head_q       <= {ptr_w_lp{1'b0}};
      tail_q       <= {ptr_w_lp{1'b0}};
      count_q      <= {cnt_w_lp{1'b0}};
      w_v_q        <= 1'b0;
      w_idx_q      <= {bht_idx_width_p{1'b0}};
      correct_q    <= 1'b0;
      actual_q     <= 1'b0;
      mispredict_q <= 1'b0;
      stat_q       <= {stat_width_p{1'b0}};
      err_q        <= 1'b0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      w_v_q        <= w_v_d;
      w_idx_q      <= w_idx_d;
      correct_q    <= correct_d;
      actual_q     <= actual_d;
      mispredict_q <= mispredict_d;
      stat_q       <= stat_d;
      err_q        <= err_d;
    end
  end

  // Entry storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_idx_q[tail_q]   <= pred_idx_i;
      mem_taken_q[tail_q] <= pred_taken_i;
    end
  end

  assign w_v_o            = w_v_q;
  assign w_idx_o          = w_idx_q;
  assign correct_o        = correct_q;
  assign actual_taken_o   = actual_q;
  assign mispredict_o     = mispredict_q;
  assign count_o          = count_q;
  assign mispredict_cnt_o = stat_q;
  assign err_o            = err_q;

endmodule

// File: tb/tb_bht_update_queue.sv
// Directed plus random stimulus for bht_update_queue, checked against a queue-based model.
module tb_bht_update_queue;

  localparam int IW    = 10;
  localparam int DEPTH = 4;
  localparam int SW    = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           pred_v = 1'b0;
  logic [IW-1:0]  pred_idx = '0;
  logic           pred_taken = 1'b0;
  logic           pred_ready;
  logic           res_v = 1'b0;
  logic           res_taken = 1'b0;
  logic           flush = 1'b0;
  logic           w_v;
  logic [IW-1:0]  w_idx;
  logic           correct;
  logic           actual_taken;
  logic           mispredict;
  logic [CW-1:0]  count;
  logic [SW-1:0]  mcnt;
  logic           err;

  bht_update_queue #(.bht_idx_width_p(IW), .depth_p(DEPTH), .stat_width_p(SW)) dut (
    .clk_i(clk), .reset_i(reset),
    .pred_v_i(pred_v), .pred_idx_i(pred_idx), .pred_taken_i(pred_taken),
    .pred_ready_o(pred_ready),
    .res_v_i(res_v), .res_taken_i(res_taken), .flush_i(flush),
    .w_v_o(w_v), .w_idx_o(w_idx), .correct_o(correct),
    .actual_taken_o(actual_taken), .mispredict_o(mispredict),
    .count_o(count), .mispredict_cnt_o(mcnt), .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; bit taken; } entry_t;
  entry_t q[$];
  int m_wv, m_idx, m_corr, m_act, m_mis, m_cnt, m_err;
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_wv = 0; m_idx = 0; m_corr = 0; m_act = 0; m_mis = 0; m_cnt = 0; m_err = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".w_v"},     int'(w_v),          m_wv);
    chk({tag, ".w_idx"},   int'(w_idx),        m_idx);
    chk({tag, ".correct"}, int'(correct),      m_corr);
    chk({tag, ".actual"},  int'(actual_taken), m_act);
    chk({tag, ".mispred"}, int'(mispredict),   m_mis);
    chk({tag, ".count"},   int'(count),        q.size());
    chk({tag, ".mcnt"},    int'(mcnt),         m_cnt);
    chk({tag, ".err"},     int'(err),          m_err);
  endtask

  // Called just after a falling edge: drive, advance one cycle, compare at the next falling edge.
  task automatic step(input string tag, input bit pv, input int pidx, input bit pt,
                      input bit rv, input bit rt, input bit fl);
    bit ready;
    entry_t e;
    pred_v = pv; pred_idx = IW'(pidx); pred_taken = pt;
    res_v = rv; res_taken = rt; flush = fl;
    #1;
    ready = (q.size() < DEPTH);
    chk({tag, ".ready"}, int'(pred_ready), int'(ready));
    @(posedge clk);
    if (rv && q.size() == 0) m_err = 1;
    if (rv && q.size() > 0) begin
      e = q.pop_front();
      m_wv = 1; m_idx = e.idx; m_act = rt;
      m_corr = (e.taken == rt); m_mis = !m_corr;
      if (m_mis && m_cnt < (1 << SW) - 1) m_cnt++;
    end else begin
      m_wv = 0; m_mis = 0;
    end
    if (fl) q.delete();
    else if (pv && ready) q.push_back('{idx: pidx, taken: pt});
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("rst.w_v", int'(w_v), 0);
    chk("rst.count", int'(count), 0);
    chk("rst.mcnt", int'(mcnt), 0);
    chk("rst.err", int'(err), 0);
    chk("rst.w_idx", int'(w_idx), 0);
    chk("rst.mispred", int'(mispredict), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst.ready", int'(pred_ready), 1);
  endtask

  initial begin
    model_reset();
    pred_v = 1'b0; res_v = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    chk("por.count", int'(count), 0);
    chk("por.w_v", int'(w_v), 0);
    reset = 1'b0;
    #1 chk("por.ready", int'(pred_ready), 1);
    @(negedge clk);

    // In-order updates with correctness
    step("ord.p0", 1, 'h005, 1, 0, 0, 0);
    step("ord.p1", 1, 'h00A, 0, 0, 0, 0);
    step("ord.p2", 1, 'h3FF, 1, 0, 0, 0);
    step("ord.r0", 0, 0, 0, 1, 1, 0);
    chk("ord.idx0", int'(w_idx), 'h005);
    step("ord.r1", 0, 0, 0, 1, 1, 0);
    chk("ord.corr1", int'(correct), 0);
    step("ord.r2", 0, 0, 0, 1, 0, 0);
    chk("ord.idx2", int'(w_idx), 'h3FF);
    chk("ord.mcnt", int'(mcnt), 2);
    step("ord.idle", 0, 0, 0, 0, 0, 0);

    // Full queue drops a push even with a same-cycle pop
    do_reset();
    for (int i = 0; i < DEPTH; i++) step("full.push", 1, 'h100 + i, i[0], 0, 0, 0);
    #1 chk("full.ready", int'(pred_ready), 0);
    step("full.pp", 1, 'h1FF, 1, 1, 0, 0);
    chk("full.count", int'(count), 3);
    step("full.pop2", 0, 0, 0, 1, 1, 0);
    chk("full.idx2", int'(w_idx), 'h101);

    // Resolve on empty queue
    do_reset();
    step("empty.r", 1, 'h011, 1, 1, 1, 0);
    chk("empty.err", int'(err), 1);
    step("empty.hold", 0, 0, 0, 0, 0, 0);
    chk("empty.sticky", int'(err), 1);

    // Flush with the redirecting resolution
    do_reset();
    step("fl.p0", 1, 'h020, 1, 0, 0, 0);
    step("fl.p1", 1, 'h021, 0, 0, 0, 0);
    step("fl.p2", 1, 'h022, 1, 0, 0, 0);
    step("fl.fr", 1, 'h023, 1, 1, 0, 1);
    chk("fl.idx", int'(w_idx), 'h020);
    chk("fl.count", int'(count), 0);
    step("fl.after", 0, 0, 0, 1, 0, 0);

    // Wrap: back-to-back push+pop across pointer wrap
    do_reset();
    step("wrap.seed", 1, $urandom_range(1023), $urandom_range(1), 0, 0, 0);
    for (int i = 0; i < 10; i++)
      step("wrap.pp", 1, $urandom_range(1023), $urandom_range(1), 1, $urandom_range(1), 0);

    // Saturating mispredict counter
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step("sat.push", 1, 'h040 + i, 1, 0, 0, 0);
      step("sat.pop", 0, 0, 0, 1, 0, 0);
    end
    chk("sat.mcnt", int'(mcnt), 3);

    // Mid-operation async reset
    step("mid.p0", 1, 'h0AA, 1, 0, 0, 0);
    step("mid.p1", 1, 'h0BB, 1, 1, 0, 0);
    do_reset();

    // Random traffic
    for (int i = 0; i < 400; i++)
      step("rnd", $urandom_range(99) < 60, $urandom_range(1023), $urandom_range(1),
           $urandom_range(99) < 45, $urandom_range(1), $urandom_range(99) < 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
